// File: rtl/conv_pkg.sv
// Shared definitions for the conv_core load engines: loader FSM encoding and
// default bus widths.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } load_state_e;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
  localparam int DEF_CW = 16;
  localparam int DEF_RD_LATENCY = 2;

endpackage

// File: rtl/valid_pipe.sv
// Delays a read-request strobe by DEPTH cycles so it lines up with RAM data;
// any_vld reports reads still in flight. No backpressure: every entry drains.
module valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic vld_in,
  output logic vld_out,
  output logic any_vld
);

  logic [DEPTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = vld_in;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pipe_q <= '0;
    else      pipe_q <= pipe_d;
  end

  assign vld_out = pipe_q[DEPTH-1];
  assign any_vld = |pipe_q;

endmodule

// File: rtl/tile_ram_to_fifo.sv
// Streams a row_num x row_len tile from a fixed-latency RAM into a load FIFO;
// first push RD_LATENCY+1 cycles after start. almost_full only gates new reads.
module tile_ram_to_fifo
  import conv_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int CW         = DEF_CW,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] row_len,
  input  logic [CW-1:0] row_num,
  input  logic [CW-1:0] row_stride,
  output logic          busy,
  output logic          done,
  output logic          ram_rd_ena,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] data_from_ram,
  output logic          fifo_push,
  input  logic          fifo_almost_full,
  output logic [DW-1:0] data_to_fifo
);

  load_state_e   state_q, state_d;
  logic [CW-1:0] len_q, len_d, num_q, num_d, stride_q, stride_d;
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic [AW-1:0] row_base_q, row_base_d, addr_q, addr_d;
  logic          rd_ena_q, rd_ena_d, busy_q, busy_d, done_q, done_d;
  logic          pipe_tail, pipe_any;

  valid_pipe #(.DEPTH(RD_LATENCY)) u_valid_pipe (
    .clk     (clk),
    .rst     (rst),
    .vld_in  (rd_ena_q),
    .vld_out (pipe_tail),
    .any_vld (pipe_any)
  );

  // addr_q/col_q/row_q describe the request currently on the RAM port;
  // they advance only on cycles where that request was actually presented.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    num_d      = num_q;
    stride_d   = stride_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    rd_ena_d   = rd_ena_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (row_len == '0 || row_num == '0) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d    = ST_ISSUE;
            len_d      = row_len;
            num_d      = row_num;
            stride_d   = row_stride;
            col_d      = '0;
            row_d      = '0;
            row_base_d = base_addr;
            addr_d     = base_addr;
            rd_ena_d   = ~fifo_almost_full;
          end
        end
      end
      ST_ISSUE: begin
        rd_ena_d = ~fifo_almost_full;
        if (rd_ena_q) begin
          if (col_q == len_q - CW'(1)) begin
            if (row_q == num_q - CW'(1)) begin
              state_d  = ST_DRAIN;
              rd_ena_d = 1'b0;
            end else begin
              col_d      = '0;
              row_d      = row_q + CW'(1);
              row_base_d = row_base_q + AW'(stride_q);
              addr_d     = row_base_q + AW'(stride_q);
            end
          end else begin
            col_d  = col_q + CW'(1);
            addr_d = addr_q + AW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!pipe_any) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      num_q      <= '0;
      stride_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      rd_ena_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      num_q      <= num_d;
      stride_q   <= stride_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      rd_ena_q   <= rd_ena_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign ram_rd_ena   = rd_ena_q;
  assign ram_addr     = addr_q;
  assign fifo_push    = pipe_tail;
  assign data_to_fifo = pipe_tail ? data_from_ram : '0;

endmodule

// File: doc/tile_ram_to_fifo.md
Name: tile_ram_to_fifo

Overview:
Parametrised successor to the flat ram_to_fifo loader: streams a 2-D sub-tile (row_num rows × row_len words, rows row_stride words apart, starting at base_addr) from a fixed-latency on-chip/outside RAM into a conv_core load FIFO. Geometry is runtime-configurable, RAM read latency is a parameter, and reads in flight are tracked so FIFO backpressure never drops data. One instance per input stream (in_fm, weight, out_fm load).

Parameters:
AW, 32, RAM address width
DW, 32, data width
CW, 16, width of row_len / row_num / row_stride counters
RD_LATENCY, 2, cycles from ram_addr/ram_rd_ena to valid data_from_ram (≥1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset (asserted when 0)
start  input  1  one-cycle pulse; latches configuration, begins transfer
base_addr  input  AW  word address of tile element (0,0)
row_len  input  CW  words per row
row_num  input  CW  number of rows
row_stride  input  CW  word distance between consecutive row starts
busy  output  1  high from cycle after accepted start until done pulse inclusive
done  output  1  one-cycle pulse when last word pushed
ram_rd_ena  output  1  read request this cycle
ram_addr  output  AW  read address
data_from_ram  input  DW  read data, valid RD_LATENCY cycles after request
fifo_push  output  1  push data_to_fifo this cycle
fifo_almost_full  input  1  FIFO has ≤ RD_LATENCY+1 free slots
data_to_fifo  output  DW  data to FIFO

Behaviour:
- Reset (rst=0, async): state IDLE; busy, done, ram_rd_ena, fifo_push = 0; ram_addr, data_to_fifo = 0; all counters and valid pipe cleared. Reset mid-transfer aborts without done; in-flight data discarded.
- FSM: IDLE → ISSUE on start (config nonzero); IDLE → FINISH on start with row_len==0 or row_num==0 (zero-length: done pulses cycle after start, no reads/pushes). ISSUE → DRAIN when last read issued. DRAIN → FINISH when valid pipe empty. FINISH → IDLE, done=1 for that one cycle, busy still 1.
- start while busy ignored; configuration only sampled at accepted start.
- Issue: in ISSUE, ram_rd_ena=1 iff fifo_almost_full==0; one word per cycle. Address = row_base + col; col increments 0..row_len-1, then col←0, row_base←row_base+row_stride, row++. row_base starts at base_addr. Arithmetic modulo 2^AW (wrap, no error).
- ram_addr and ram_rd_ena registered; first request the cycle after start.
- Valid pipe: RD_LATENCY-deep shift register of ram_rd_ena. fifo_push = pipe tail; data_to_fifo = data_from_ram combinationally on push cycles (registered copy held otherwise is not required; only push-cycle value is specified). Order of pushes equals order of addresses.
- Backpressure: stall only affects issue; in-flight reads always complete and push. Threshold contract guarantees no overflow. almost_full deasserting resumes issue next cycle at the held address.
- Throughput: with almost_full=0, exactly one push per cycle; total cycles start→done = row_len·row_num + RD_LATENCY + 2.
- Exactly row_len·row_num pushes per transfer.

Decomposition:
- Shared package conv_pkg: FSM state encoding (IDLE, ISSUE, DRAIN, FINISH), default AW/DW/CW constants.
- One sub-module natural: valid_pipe (parametrised RD_LATENCY shift register of 1-bit valid, async active-low reset); same RAM model as the conv bench (two register stages) matches RD_LATENCY=2.

Test Plan:
- Flat tile: base=0, row_len=16, row_num=1, stride=16, mem[i]=i, almost_full=0 → pushes 0..15 consecutively, first push 3 cycles after start, done 20 cycles after start.
- 2-D tile: base=0x10, row_len=4, row_num=3, stride=8 → pushed data from addresses 0x10–0x13, 0x18–0x1B, 0x20–0x23, 12 pushes, one done pulse.
- Backpressure: 64-word transfer, almost_full held high cycles 10–29 → no rd_ena during stall, ≤RD_LATENCY pushes after rise, all 64 words in order, none duplicated or lost.
- Zero length: row_len=0, row_num=5 → no ram_rd_ena, no push, done exactly one cycle after start.
- Start while busy: second start mid-transfer with different base → ignored, first transfer completes unchanged, single done.
- Reset mid-transfer: rst=0 after 7 pushes → all outputs 0 immediately; new start after release performs full transfer from its own base.
